// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for a quadrature (A/B) incremental encoder. It synchronises the
// asynchronous channels, deglitches them, and then decodes Gray-code steps into
// ENABLE/DOWN controls for an up/down position counter. Illegal transitions
// (both channels changing at once) are flagged and counted.
//
// Parameters
//   FILTER_LEN : consecutive identical synchronised samples required before the
//                filtered value updates (1..15)
//   ERR_W      : width of ERR_COUNT
//
// Ports
//   CLK        in   system clock, all logic on the rising edge
//   RST        in   synchronous active-low reset
//   A, B       in   encoder channels (asynchronous to CLK)
//   Z          in   index channel (only with QUAD_INDEX_EN)
//   CLEAR      in   synchronous clear of ERR_COUNT / ERR_SAT
//   ENABLE     out  one-cycle step pulse
//   DOWN       out  direction of last valid step (0 = up, 1 = down)
//   ERROR      out  one-cycle pulse on an illegal transition
//   ERR_COUNT  out  saturating count of illegal transitions
//   ERR_SAT    out  sticky: error seen while ERR_COUNT was all ones
//   PHASE      out  current filtered {A,B}
//   INDEX      out  one-cycle index pulse (only with QUAD_INDEX_EN)
//
// Optional feature: define QUAD_INDEX_EN to add the Z input and INDEX output.
// -----------------------------------------------------------------------------

// Run-length deglitch filter for a group of synchronised bits. The output only
// moves once the same differing sample has been seen FILTER_LEN times in a row.
module quad_step_decoder_filt #(
   parameter int W          = 2,
   parameter int FILTER_LEN = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,   // force output to din (used when leaving INIT)
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam logic [3:0] FL = 4'(FILTER_LEN);

   logic [W-1:0] filt_q, filt_d;
   logic [W-1:0] cand_q, cand_d;
   logic [3:0]   run_q, run_d;
   logic [3:0]   run_nx;

   always_comb begin
      filt_d = filt_q;
      cand_d = cand_q;
      run_d  = run_q;
      run_nx = 4'd1;
      if (load) begin
         filt_d = din;
         cand_d = din;
         run_d  = '0;
      end else if (din == filt_q) begin
         run_d = '0;
      end else begin
         // A new differing value restarts the run at 1.
         if (run_q != '0 && din == cand_q) run_nx = run_q + 4'd1;
         cand_d = din;
         if (run_nx == FL) begin
            filt_d = din;
            run_d  = '0;
         end else begin
            run_d = run_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         filt_q <= '0;
         cand_q <= '0;
         run_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cand_q <= cand_d;
         run_q  <= run_d;
      end
   end

   assign dout = filt_q;

endmodule

module quad_step_decoder #(
   parameter int FILTER_LEN = 2,
   parameter int ERR_W      = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             A,
   input  logic             B,
`ifdef QUAD_INDEX_EN
   input  logic             Z,
`endif
   input  logic             CLEAR,
   output logic             ENABLE,
   output logic             DOWN,
   output logic             ERROR,
   output logic [ERR_W-1:0] ERR_COUNT,
   output logic             ERR_SAT,
`ifdef QUAD_INDEX_EN
   output logic             INDEX,
`endif
   output logic [1:0]       PHASE
);

   typedef enum logic {S_INIT, S_TRACK} state_t;

   // INIT ends on the (FILTER_LEN+2)th edge after reset release.
   localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);

`ifdef QUAD_INDEX_EN
   localparam int NCH = 3;
   logic [NCH-1:0] raw;
   assign raw = {Z, A, B};
`else
   localparam int NCH = 2;
   logic [NCH-1:0] raw;
   assign raw = {A, B};
`endif

   // ---------------- two-flop synchroniser ----------------
   logic [NCH-1:0] sync1_q, sync1_d;
   logic [NCH-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // ---------------- deglitch filters ----------------
   logic       filt_load;
   logic [1:0] filt_ab;

   quad_step_decoder_filt #(.W(2), .FILTER_LEN(FILTER_LEN)) u_filt_ab (
      .clk  (CLK),
      .rst  (RST),
      .load (filt_load),
      .din  (sync2_q[1:0]),
      .dout (filt_ab)
   );

`ifdef QUAD_INDEX_EN
   // Z is filtered on its own so index activity never restarts the A/B run.
   logic filt_z;

   quad_step_decoder_filt #(.W(1), .FILTER_LEN(FILTER_LEN)) u_filt_z (
      .clk  (CLK),
      .rst  (RST),
      .load (filt_load),
      .din  (sync2_q[2]),
      .dout (filt_z)
   );
`endif

   // ---------------- step decode FSM ----------------
   state_t           state_q, state_d;
   logic [4:0]       init_cnt_q, init_cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic             enable_q, enable_d;
   logic             down_q, down_d;
   logic             error_q, error_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_sat_q, err_sat_d;
   logic             fwd, rev;
`ifdef QUAD_INDEX_EN
   logic             index_q, index_d;
`endif

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      phase_d    = phase_q;
      enable_d   = 1'b0;
      error_d    = 1'b0;
      down_d     = down_q;
      filt_load  = 1'b0;
      fwd        = 1'b0;
      rev        = 1'b0;

      case (state_q)
         S_INIT: begin
            // Adopt whatever the inputs currently show; no step is reported.
            if (init_cnt_q == INIT_LAST) begin
               filt_load = 1'b1;
               phase_d   = sync2_q[1:0];
               state_d   = S_TRACK;
            end else begin
               init_cnt_d = init_cnt_q + 5'd1;
            end
         end
         S_TRACK: begin
            if (filt_ab != phase_q) begin
               phase_d = filt_ab;
               case ({phase_q, filt_ab})
                  4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
                  4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
                  default:                            error_d = 1'b1;
               endcase
               enable_d = fwd | rev;
               if (fwd | rev) down_d = rev;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

`ifdef QUAD_INDEX_EN
   always_comb begin
      index_d = enable_d && (filt_ab == 2'b00) && filt_z;
   end
`endif

   // CLEAR has priority over a coincident error; the ERROR pulse itself is
   // unaffected.
   always_comb begin
      err_cnt_d = err_cnt_q;
      err_sat_d = err_sat_q;
      if (CLEAR) begin
         err_cnt_d = '0;
         err_sat_d = 1'b0;
      end else if (error_d) begin
         if (&err_cnt_q) err_sat_d = 1'b1;
         else            err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         phase_q    <= 2'b00;
         enable_q   <= 1'b0;
         down_q     <= 1'b0;
         error_q    <= 1'b0;
         err_cnt_q  <= '0;
         err_sat_q  <= 1'b0;
`ifdef QUAD_INDEX_EN
         index_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         phase_q    <= phase_d;
         enable_q   <= enable_d;
         down_q     <= down_d;
         error_q    <= error_d;
         err_cnt_q  <= err_cnt_d;
         err_sat_q  <= err_sat_d;
`ifdef QUAD_INDEX_EN
         index_q    <= index_d;
`endif
      end
   end

   assign ENABLE    = enable_q;
   assign DOWN      = down_q;
   assign ERROR     = error_q;
   assign ERR_COUNT = err_cnt_q;
   assign ERR_SAT   = err_sat_q;
   assign PHASE     = phase_q;
`ifdef QUAD_INDEX_EN
   assign INDEX     = index_q;
`endif

endmodule
